prra_pkt_mux: RTL
=================

// Module: prra_pkt_mux
// PURPOSE
//  Packet-level N:1 stream multiplexer placed directly downstream of prra.
//  - Presents pending input streams to prra as a request vector.
//  - Captures the one-hot grant and locks onto the winning port for a whole packet (until in_last).
//  - Forwards that packet through a registered valid/ready output stage.
//  - Releases the lock after the last beat so prra can arbitrate again.
// PARAMETERS
//  WIDTH       4   number of input ports; must equal prra WIDTH
//  LOG2_WIDTH  2   log2(WIDTH); width of out_port
//  DATA_WIDTH  32  payload bits per beat
//  PIPELINE    0   prra PIPELINE setting; grant arrives PIPELINE+1 cycles after request
// PORTS
//  clk          in   1                 clock; all logic on posedge
//  srst         in   1                 reset, asynchronous, active-high
//  in_valid     in   WIDTH             per-port beat valid
//  in_last      in   WIDTH             per-port end-of-packet marker
//  in_data      in   WIDTH*DATA_WIDTH  port p on bits [p*DATA_WIDTH +: DATA_WIDTH]
//  in_ready     out  WIDTH             per-port beat accept
//  arb_request  out  WIDTH             to prra.request
//  arb_grant    in   WIDTH             from prra.grant; one-hot or zero
//  out_valid    out  1                 output beat valid (registered)
//  out_last     out  1                 output end-of-packet (registered)
//  out_data     out  DATA_WIDTH        output payload (registered)
//  out_port     out  LOG2_WIDTH        source port index of the current output beat
//  out_ready    in   1                 downstream accept
//  grant_err    out  1                 one-cycle pulse: arb_grant had >1 bit set
// BEHAVIOUR
//  Reset (async, srst=1):
//   - Outputs: state=IDLE; out_valid=0, out_last=0, out_data=0, out_port=0; arb_request=0; in_ready=0; grant_err=0.
//   - An in-flight packet is abandoned. No beat is replayed after reset.
//  FSM states:
//   - IDLE:
//     - arb_request=0, in_ready=0.
//     - If in_valid!=0 -> ARB; load wait counter with PIPELINE+1.
//   - ARB:
//     - arb_request=in_valid, updated every cycle. Counter decrements each cycle.
//     - arb_grant!=0 -> XFER. Latch sel=index of lowest set bit.
//       - If popcount(arb_grant)>1, pulse grant_err for one cycle.
//     - Counter reaches 0 with arb_grant==0 (request withdrawn) -> IDLE.
//   - XFER:
//     - arb_request=0.
//     - in_ready[sel] = !out_valid | out_ready; all other in_ready bits are 0.
//     - Beat accepted when in_valid[sel] & in_ready[sel]:
//       - out_data <= in_data[sel]; out_last <= in_last[sel]; out_port <= sel; out_valid <= 1.
//     - Accepted beat with in_last[sel]=1 -> IDLE.
//  Output stage:
//   - One-entry register.
//   - out_valid clears on out_valid & out_ready when no new beat is loaded in the same cycle.
//   - out_* are held stable while out_valid=1 and out_ready=0.
//  Throughput and latency:
//   - 1 beat/cycle sustained while out_ready=1.
//   - Input-to-output latency: 1 cycle.
//   - Packet switch overhead: 2+PIPELINE cycles (IDLE, ARB wait) after the last beat.
//  Boundaries:
//   - Single-beat packets (valid & last together) are legal.
//   - Input stalls (in_valid[sel]=0) in XFER keep the lock. No timeout.
//   - New requests from other ports during XFER are ignored until IDLE; round-robin fairness stays with prra.
//   - The last beat may be accepted while out_ready=0, provided the register is empty.
//   - A grant bit for a port whose in_valid has dropped is still honoured: XFER waits for that port.
// TESTING (bench instantiates prra + prra_pkt_mux, WIDTH=4, PIPELINE=0, out_ready=1 unless stated)
//  1. Reset: srst=1 for 5 cycles with random inputs -> all outputs 0. Assert srst mid-packet -> out_valid=0 on the next edge.
//  2. Single port: port2 sends 3-beat packet A0..A2 -> out_data=A0,A1,A2 on consecutive cycles, out_port=2, out_last only on A2.
//  3. Round robin: ports 0,1,3 each send 2-beat packets, all in_valid=4'b1011 -> packets emerge in prra order. No beats interleave across ports.
//  4. Backpressure: out_ready toggles 1,0,0,1 during a 4-beat packet -> out_data held while stalled. Beats neither lost nor duplicated; in_ready[sel]=0 while stalled.
//  5. Single-beat packets back-to-back from ports 1 and 2 -> each takes 3 cycles (IDLE, ARB, XFER). out_last=1 on every beat.
//  6. Forced arb_grant=4'b0110 (prra bypassed) -> grant_err=1 for one cycle, sel=1; only port 1 is forwarded.

Source files
------------

// File: rtl/prra_pkt_mux.sv
// Packet-level N:1 stream multiplexer that sits downstream of the prra arbiter.
// It requests arbitration, locks onto the granted port for a whole packet and forwards it through a one-entry output register.
module prra_pkt_mux #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PIPELINE   = 0
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [WIDTH-1:0]            in_valid,
  input  logic [WIDTH-1:0]            in_last,
  input  logic [WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]            in_ready,
  output logic [WIDTH-1:0]            arb_request,
  input  logic [WIDTH-1:0]            arb_grant,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [LOG2_WIDTH-1:0]       out_port,
  input  logic                        out_ready,
  output logic                        grant_err
);

  // Wide enough to hold PIPELINE+1, the number of cycles a grant may take to arrive.
  localparam int CNT_W = $clog2(PIPELINE + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [LOG2_WIDTH-1:0]   sel, sel_nxt;
  logic                    accept;
  logic                    take_slot;
  logic                    grant_multi;
  logic [DATA_WIDTH-1:0]   in_data_a [WIDTH];

  for (genvar p = 0; p < WIDTH; p++) begin : g_unpack
    assign in_data_a[p] = in_data[p*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [LOG2_WIDTH-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = LOG2_WIDTH'(i);
    end
  endfunction

  // NOTE: every output of this block gets a default before the case statement, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sel_nxt     = sel;
    arb_request = '0;
    in_ready    = '0;
    accept      = 1'b0;
    grant_multi = 1'b0;
    take_slot   = !out_valid || out_ready;

    case (state)
      IDLE: begin
        if (|in_valid) begin
          state_nxt = ARB;
          cnt_nxt   = CNT_W'(PIPELINE + 1);
        end
      end

      ARB: begin
        arb_request = in_valid;
        cnt_nxt     = cnt - CNT_W'(1);
        if (|arb_grant) begin
          state_nxt   = XFER;
          sel_nxt     = lowest_idx(arb_grant);
          grant_multi = (arb_grant & (arb_grant - WIDTH'(1))) != '0;
        end else if (cnt <= CNT_W'(1)) begin
          // The grant window has closed without a winner; the request was withdrawn.
          state_nxt = IDLE;
        end
      end

      XFER: begin
        in_ready[sel] = take_slot;
        accept        = in_valid[sel] && take_slot;
        if (accept && in_last[sel]) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      grant_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      grant_err <= grant_multi;
    end
  end

  // NOTE: the payload register is reset too, because out_data must read zero after reset rather than stale data.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_last  <= in_last[sel];
      out_data  <= in_data_a[sel];
      out_port  <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
